// File: rtl/fir_filter_param_if.sv
// Sample/coefficient bus for fir_filter_param: input handshake, output handshake,
// coefficient write port and synchronous flush.
interface fir_filter_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              coef_wr;
  logic [4:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;

  modport master (
    output clear, in_valid, in_data, out_ready, coef_wr, coef_addr, coef_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready, coef_wr, coef_addr, coef_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_filter_param.sv
// Sequential single-MAC FIR: one sample accepted in IDLE, TAPS MAC cycles,
// then a rounded, saturated result held in OUT until taken downstream.
module fir_tap #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              coef_we,
  input  logic [DATA_W-1:0] d_in,
  input  logic [COEF_W-1:0] coef_in,
  output logic [DATA_W-1:0] d_out,
  output logic [COEF_W-1:0] c_out
);
  logic [DATA_W-1:0] d_q, d_d;
  logic [COEF_W-1:0] c_q, c_d;

  // clear flushes history only; coefficients survive it
  always_comb begin
    d_d = d_q;
    c_d = c_q;
    if (clear)         d_d = '0;
    else if (shift_en) d_d = d_in;
    if (coef_we)       c_d = coef_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      c_q <= '0;
    end else begin
      d_q <= d_d;
      c_q <= c_d;
    end
  end

  assign d_out = d_q;
  assign c_out = c_q;
endmodule

module fir_filter_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 0
) (
  input logic               clk,
  input logic               rst_n,
  fir_filter_param_if.slave bus
);
  localparam int IW = $clog2(TAPS);
  localparam int AW = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [AW:0] RND_ADD = ((AW+1)'(1) << SHIFT) >> 1;
  localparam logic signed [AW:0] SAT_MAX = {{(AW+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]        out_q, out_d;

  logic [TAPS-1:0][DATA_W-1:0] d_taps;
  logic [TAPS-1:0][DATA_W-1:0] tap_in;
  logic [TAPS-1:0][COEF_W-1:0] c_taps;
  logic                        shift_en;
  logic                        coef_ok;

  logic [DATA_W-1:0]    d_sel;
  logic [COEF_W-1:0]    c_sel;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW:0]   rnd;
  logic signed [AW:0]   shifted;
  logic [DATA_W-1:0]    sat_val;

  assign tap_in  = {d_taps[TAPS-2:0], bus.in_data};
  assign coef_ok = (state_q == IDLE) && bus.coef_wr && !bus.clear &&
                   ({1'b0, bus.coef_addr} < 6'(TAPS));

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_tap (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clear),
      .shift_en (shift_en),
      .coef_we  (coef_ok && (bus.coef_addr == 5'(k))),
      .d_in     (tap_in[k]),
      .coef_in  (bus.coef_data),
      .d_out    (d_taps[k]),
      .c_out    (c_taps[k])
    );
  end

  // full-precision product and running sum; the result path rounds then clamps
  always_comb begin
    d_sel   = d_taps[idx_q];
    c_sel   = c_taps[idx_q];
    prod    = $signed(d_sel) * $signed(c_sel);
    acc_sum = acc_q + AW'(prod);
    rnd     = (AW+1)'(acc_sum) + RND_ADD;
    shifted = rnd >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = shifted[DATA_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    out_d    = out_q;
    shift_en = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      idx_d   = '0;
      acc_d   = '0;
      out_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          shift_en = 1'b1;
          idx_d    = '0;
          acc_d    = '0;
          state_d  = MAC;
        end
        MAC: begin
          acc_d = acc_sum;
          if (idx_q == IW'(TAPS-1)) begin
            idx_d   = '0;
            out_d   = sat_val;
            state_d = OUT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        OUT: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_fir_filter_param.sv
// Two TAPS=4 instances (SHIFT=0 and SHIFT=2) driven in lockstep; a scoreboard
// fed by a sum-of-products model is drained by per-instance output monitors.
module tb_fir_filter_param;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int T  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1, coef_wr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] coef_data = '0;
  logic [4:0]    coef_addr = '0;
  bit            bp = 1'b0;

  fir_filter_param_if #(.DATA_W(DW), .COEF_W(CW)) bus0 ();
  fir_filter_param_if #(.DATA_W(DW), .COEF_W(CW)) bus1 ();

  assign bus0.clear = clear;         assign bus1.clear = clear;
  assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
  assign bus0.in_data = in_data;     assign bus1.in_data = in_data;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
  assign bus0.coef_wr = coef_wr;     assign bus1.coef_wr = coef_wr;
  assign bus0.coef_addr = coef_addr; assign bus1.coef_addr = coef_addr;
  assign bus0.coef_data = coef_data; assign bus1.coef_data = coef_data;

  fir_filter_param #(.DATA_W(DW), .COEF_W(CW), .TAPS(T), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  fir_filter_param #(.DATA_W(DW), .COEF_W(CW), .TAPS(T), .SHIFT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0, failures = 0, pops0 = 0, pops1 = 0;
  longint mc[T];
  longint hist[T];
  logic [DW-1:0] q0[$], q1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // y = sat( round( sum_k x[n-k]*c[k] / 2^s ) )
  function automatic logic [DW-1:0] model_out(input int s);
    longint sum = 0;
    for (int k = 0; k < T; k++) sum += hist[k] * mc[k];
    if (s > 0) sum = (sum + (64'sd1 << (s - 1))) >>> s;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  function automatic void model_accept(input logic [DW-1:0] x);
    for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(x));
    q0.push_back(model_out(0));
    q1.push_back(model_out(2));
  endfunction

  function automatic void model_flush(input bit coefs_too);
    q0.delete();
    q1.delete();
    for (int k = 0; k < T; k++) begin
      hist[k] = 0;
      if (coefs_too) mc[k] = 0;
    end
  endfunction

  always @(negedge clk) if (rst_n && bus0.out_valid && out_ready) begin
    if (q0.size() == 0) timeout("out0_unexpected");
    else chk("out0", bus0.out_data, q0.pop_front());
    pops0++;
  end

  always @(negedge clk) if (rst_n && bus1.out_valid && out_ready) begin
    if (q1.size() == 0) timeout("out1_unexpected");
    else chk("out1", bus1.out_data, q1.pop_front());
    pops1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus0.in_ready && n < 200) begin
      if (bp) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!bus0.in_ready) timeout("wait_idle");
  endtask

  task automatic send(input logic [DW-1:0] x);
    wait_idle();
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    model_accept(x);
    #1 in_valid = 1'b0;
  endtask

  task automatic coef_write(input int addr, input logic [CW-1:0] v);
    wait_idle();
    coef_wr   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = v;
    @(posedge clk);
    if (addr < T) mc[addr] = longint'($signed(v));
    #1 coef_wr = 1'b0;
  endtask

  task automatic send_coef(input logic [DW-1:0] x, input int addr, input logic [CW-1:0] v);
    wait_idle();
    coef_wr = 1'b1; coef_addr = 5'(addr); coef_data = v;
    in_valid = 1'b1; in_data = x;
    @(posedge clk);
    if (addr < T) mc[addr] = longint'($signed(v));
    model_accept(x);
    #1;
    coef_wr = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) timeout("drain");
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int n, p;
    bit seen;
    logic [DW-1:0] held0, held1;
    model_flush(1'b1);

    // reset state
    #1;
    repeat (3) tick();
    chk("rst_out_valid0", bus0.out_valid, 0);
    chk("rst_out_data0", bus0.out_data, 0);
    chk("rst_out_valid1", bus1.out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus0.in_ready, 1);

    // impulse response with latency check; addr 7 is out of range
    coef_write(0, 4); coef_write(1, 8); coef_write(2, 8); coef_write(3, 4);
    coef_write(7, 16'h1234);
    wait_idle();
    in_valid = 1'b1; in_data = 16'd1;
    @(posedge clk);
    model_accept(16'd1);
    #1 in_valid = 1'b0;
    n = 0;
    while (!bus0.out_valid && n < 20) begin tick(); n++; end
    chk("latency", n + 1, T + 1);
    for (int i = 0; i < 4; i++) send(16'd0);
    drain();

    // saturation both ways
    for (int k = 0; k < T; k++) coef_write(k, 16'h7FFF);
    for (int i = 0; i < 4; i++) send(16'h7FFF);
    for (int i = 0; i < 4; i++) send(16'h8000);
    drain();

    // rounding on the SHIFT=2 instance
    coef_write(0, 1);
    for (int k = 1; k < T; k++) coef_write(k, 0);
    send(16'd6); send(16'hFFFA); send(16'd5);
    drain();

    // backpressure hold with in_valid ignored
    out_ready = 1'b0;
    send(16'd9);
    n = 0;
    while (!bus0.out_valid && n < 20) begin tick(); n++; end
    if (!bus0.out_valid) timeout("hold_wait");
    held0 = bus0.out_data; held1 = bus1.out_data;
    in_valid = 1'b1; in_data = 16'd123;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_stable0", bus0.out_data, held0);
      chk("hold_stable1", bus1.out_data, held1);
      chk("hold_ready", bus0.in_ready, 0);
    end
    in_valid = 1'b0;
    p = pops0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("hold_one_xfer", pops0, p + 1);
    chk("hold_idle", bus0.in_ready, 1);
    chk("hold_valid_low", bus0.out_valid, 0);
    chk("hold_sb_empty", q0.size(), 0);

    // clear mid-MAC, then clear beating accept and coef_wr on one edge
    coef_write(0, 4); coef_write(1, 8); coef_write(2, 8); coef_write(3, 4);
    send(16'd5);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_flush(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= bus0.out_valid | bus1.out_valid;
    end
    chk("clear_no_out", seen, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'd77;
    coef_wr = 1'b1; coef_addr = 5'd0; coef_data = 16'd100;
    tick();
    clear = 1'b0; in_valid = 1'b0; coef_wr = 1'b0;
    chk("clear_prio_ready", bus0.in_ready, 1);
    send(16'd1);
    for (int i = 0; i < 3; i++) send(16'd0);
    drain();

    // reset mid-MAC, then coef_wr during MAC must be ignored
    send(16'd3);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid0", bus0.out_valid, 0);
    chk("arst_data0", bus0.out_data, 0);
    chk("arst_data1", bus1.out_data, 0);
    model_flush(1'b1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("arst_ready", bus0.in_ready, 1);
    coef_write(0, 1); coef_write(1, 2); coef_write(2, 3); coef_write(3, 4);
    send(16'd1);
    coef_wr = 1'b1; coef_addr = 5'd0; coef_data = 16'd50;
    tick();
    coef_wr = 1'b0;
    for (int i = 0; i < 3; i++) send(16'd0);
    drain();

    // randomized traffic with random backpressure
    bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    coef_write(int'($urandom_range(0, 5)), 16'($urandom));
        2:       send_coef(16'($urandom), int'($urandom_range(0, 5)), 16'($urandom));
        3:       send(($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000);
        default: send(16'($urandom));
      endcase
    end
    drain();
    bp = 1'b0;

    chk("sb_empty", q0.size() + q1.size(), 0);
    chk("pops_match", pops0, pops1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_filter_param.md
FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

Interface
REQ-001 Parameter DATA_W, default 16: signed sample and output width, legal range 8..32.
REQ-002 Parameter COEF_W, default 16: signed coefficient width, legal range 8..32.
REQ-003 Parameter TAPS, default 8: number of filter taps, legal range 2..32.
REQ-004 Parameter SHIFT, default 0: output right-shift with rounding, legal range 0..(DATA_W+COEF_W-1).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 clear  in  1  synchronous flush of delay line and pipeline.
REQ-008 in_valid  in  1  input sample valid.
REQ-009 in_data  in  DATA_W  signed input sample.
REQ-010 in_ready  out  1  block can accept a sample.
REQ-011 out_valid  out  1  output sample valid.
REQ-012 out_data  out  DATA_W  signed filtered sample.
REQ-013 out_ready  in  1  downstream accepts the output.
REQ-014 coef_wr  in  1  coefficient write strobe.
REQ-015 coef_addr  in  5  tap index to write.
REQ-016 coef_data  in  COEF_W  signed coefficient value.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, MAC, OUT.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-019 IDLE: an in_valid&in_ready edge SHALL shift the delay line (d[k]<=d[k-1], d[0]<=in_data), clear the accumulator and tap index, and enter MAC.
REQ-020 MAC: each cycle SHALL add d[idx]*c[idx] to the accumulator and increment idx; the cycle with idx==TAPS-1 SHALL transition to OUT.
REQ-021 out_valid SHALL rise exactly TAPS+1 cycles after the accepting edge, i.e. after the accept edge plus TAPS MAC edges.
REQ-022 OUT: out_data and out_valid SHALL be held stable until out_ready is 1; that edge SHALL return to IDLE.
REQ-023 Maximum throughput SHALL be one sample per TAPS+2 cycles.
REQ-024 Accumulator width SHALL be DATA_W+COEF_W+ceil(log2(TAPS)), with signed, full-precision, non-wrapping arithmetic.
REQ-025 If SHIFT>0, out_data SHALL be computed as (acc + 2^(SHIFT-1)) arithmetically shifted right by SHIFT; if SHIFT=0, out_data SHALL equal acc.
REQ-026 The shifted result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 coef_wr SHALL be honoured only in IDLE with coef_addr<TAPS; otherwise it SHALL be ignored.
REQ-028 A coefficient write and a sample accept on the same IDLE edge SHALL both take effect, and the MAC SHALL use the new coefficient.
REQ-029 clear SHALL, in any state, zero the delay line, drop any in-flight or pending output, and enter IDLE with out_valid=0; coefficients SHALL be retained.
REQ-030 clear SHALL take priority over an in_valid accept and over coef_wr on the same edge.

Reset
REQ-031 While rst_n=0: state=IDLE, delay line=0, coefficients=0, accumulator=0, idx=0, out_valid=0, out_data=0, in_ready=1 after release.
REQ-032 Reset asserted mid-MAC or in OUT SHALL abort immediately, with no output produced.

Verification
REQ-033 TAPS=4, coefs {4,8,8,4}, SHIFT=0; impulse 1 followed by 0s -> out_data sequence 4,8,8,4,0.
REQ-034 TAPS=4, all coefs 0x7FFF, four inputs 0x7FFF -> 0x7FFF (saturated); four inputs 0x8000 -> 0x8000.
REQ-035 SHIFT=2, c[0]=1, others 0; input 6 -> 2; input -6 -> -1; input 5 -> 1.
REQ-036 Hold out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0, and in_valid ignored; release -> exactly one transfer, then IDLE.
REQ-037 Assert clear mid-MAC -> out_valid never asserts for that sample; next impulse yields a response with no history.
REQ-038 Pulse rst_n low mid-MAC -> all outputs 0 immediately; coef_wr during MAC ignored (read back via impulse response).
